// File: rtl/paddle_ctrl_pkg.sv
// rtl/paddle_ctrl_pkg.sv - shared pong geometry, AI FSM states and paddle motion helpers
// Geometry constants are common with the ball block and the renderer.
// Functions:
//   manual_step : one button-driven move, clamped to 0..MAX_Y
//   ai_target   : ball_y converted to a clamped paddle top offset
//   ai_step     : one AI move toward a target with deadband and speed limit
package paddle_ctrl_pkg;

  localparam int SCREEN_H   = 480;
  localparam int TOP_MARGIN = 25;
  localparam int PADDLE_H   = 72;
  localparam int BALL_SIZE  = 8;

  localparam int MAX_Y    = SCREEN_H - TOP_MARGIN - PADDLE_H;  // 383
  localparam int CENTER_Y = MAX_Y / 2;                         // 191

  localparam logic [9:0]  MAX_Y10    = 10'(MAX_Y);
  localparam logic [10:0] MAX_Y11    = 11'(MAX_Y);
  localparam logic [9:0]  CENTER_Y10 = 10'(CENTER_Y);

  // Ball centre row minus paddle half-height, shifted into paddle-offset space.
  localparam logic signed [11:0] AI_OFFSET = 12'(BALL_SIZE / 2 - TOP_MARGIN - PADDLE_H / 2);

  typedef enum logic {
    AI_MANUAL = 1'b0,
    AI_TRACK  = 1'b1
  } ai_state_t;

  // 11-bit arithmetic so that y + speed can never wrap before the clamp.
  function automatic logic [9:0] manual_step(input logic [9:0] y, input logic up,
                                             input logic dn, input int speed);
    logic [10:0] y11;
    logic [10:0] sp;
    logic [10:0] sum;
    logic [9:0]  res;
    y11 = {1'b0, y};
    sp  = 11'(speed);
    sum = y11 + sp;
    res = y;
    if (up && !dn) begin
      res = (y11 < sp) ? 10'd0 : 10'(y11 - sp);
    end else if (dn && !up) begin
      res = (sum > MAX_Y11) ? MAX_Y10 : sum[9:0];
    end
    return res;
  endfunction

  // Signed 12-bit so a ball near the top gives a negative offset that clamps to 0.
  function automatic logic [9:0] ai_target(input logic [9:0] ball_y);
    logic signed [11:0] t;
    logic [9:0]         res;
    t = $signed({2'b00, ball_y}) + AI_OFFSET;
    if (t < 12'sd0) begin
      res = 10'd0;
    end else if (t > $signed({2'b00, MAX_Y10})) begin
      res = MAX_Y10;
    end else begin
      res = 10'(t);
    end
    return res;
  endfunction

  // Moves never overshoot the target, and the target is within 0..MAX_Y,
  // so the result stays in range without a further clamp.
  function automatic logic [9:0] ai_step(input logic [9:0] y, input logic [9:0] target,
                                         input int speed, input int deadband);
    logic signed [11:0] d;
    logic signed [11:0] sp;
    logic signed [11:0] db;
    logic signed [11:0] mv;
    logic [9:0]         res;
    d   = $signed({2'b00, target}) - $signed({2'b00, y});
    sp  = 12'(speed);
    db  = 12'(deadband);
    mv  = 12'sd0;
    res = y;
    if (d > db) begin
      mv  = (d < sp) ? d : sp;
      res = 10'({2'b00, y} + mv);
    end else if (d < -db) begin
      mv  = (-d < sp) ? -d : sp;
      res = 10'({2'b00, y} - mv);
    end
    return res;
  endfunction

endpackage

// File: rtl/paddle_ctrl_if.sv
// rtl/paddle_ctrl_if.sv - game-side bundle between the frame logic and paddle_ctrl
// Signals:
//   refresh_tick        one-clk frame pulse
//   btn_up1/dn1/up2/dn2 raw asynchronous buttons
//   ai_enable           1 = player 2 driven by the AI
//   ball_y              ball top row, screen coordinates
//   paddle1_y/paddle2_y paddle top offsets, 0..MAX_Y
//   ai_active           registered AI mode in force
// Modports: master drives the inputs and reads positions; slave is paddle_ctrl.
interface paddle_ctrl_if;
  logic       refresh_tick;
  logic       btn_up1;
  logic       btn_dn1;
  logic       btn_up2;
  logic       btn_dn2;
  logic       ai_enable;
  logic [9:0] ball_y;
  logic [9:0] paddle1_y;
  logic [9:0] paddle2_y;
  logic       ai_active;

  modport master (
    output refresh_tick, btn_up1, btn_dn1, btn_up2, btn_dn2, ai_enable, ball_y,
    input  paddle1_y, paddle2_y, ai_active
  );

  modport slave (
    input  refresh_tick, btn_up1, btn_dn1, btn_up2, btn_dn2, ai_enable, ball_y,
    output paddle1_y, paddle2_y, ai_active
  );
endinterface

// File: rtl/paddle_ctrl_btn_debounce.sv
// rtl/paddle_ctrl_btn_debounce.sv - two-flop synchronizer plus hold-time debouncer for one button
// Ports:
//   clk    system clock
//   reset  synchronous, active-low
//   raw    asynchronous button level
//   stable debounced level; changes DEBOUNCE_CYCLES + 2 clk after a held raw edge
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int CW = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      count  <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any bounce back to the accepted level restarts the hold window.
      if (sync2 != stable) begin
        if (count == LAST) begin
          stable <= sync2;
          count  <= '0;
        end else begin
          count <= count + CW'(1);
        end
      end else begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - pong paddle positions: manual buttons for both players, AI tracker for player 2
// Ports:
//   clk    system clock
//   reset  synchronous, active-low
//   bus    paddle_ctrl_if.slave (frame tick, buttons, ai_enable, ball_y in; paddle positions, ai_active out)
// Positions only move on refresh_tick and appear 1 clk after it.
module paddle_ctrl
  import paddle_ctrl_pkg::*;
#(
  parameter int PADDLE_SPEED    = 3,
  parameter int AI_SPEED        = 2,
  parameter int AI_LAG          = 4,
  parameter int AI_DEADBAND     = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input logic          clk,
  input logic          reset,
  paddle_ctrl_if.slave bus
);

  localparam int LAG_W = (AI_LAG > 1) ? $clog2(AI_LAG) : 1;
  localparam logic [LAG_W-1:0] LAG_LAST = LAG_W'(AI_LAG - 1);

  logic up1_s;
  logic dn1_s;
  logic up2_s;
  logic dn2_s;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up1 (
    .clk(clk), .reset(reset), .raw(bus.btn_up1), .stable(up1_s)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn1 (
    .clk(clk), .reset(reset), .raw(bus.btn_dn1), .stable(dn1_s)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up2 (
    .clk(clk), .reset(reset), .raw(bus.btn_up2), .stable(up2_s)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn2 (
    .clk(clk), .reset(reset), .raw(bus.btn_dn2), .stable(dn2_s)
  );

  ai_state_t        state_q,  state_d;
  logic [LAG_W-1:0] lag_q,    lag_d;
  logic [9:0]       target_q, target_d;
  logic [9:0]       p1_q,     p1_d;
  logic [9:0]       p2_q,     p2_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= AI_MANUAL;
      lag_q    <= '0;
      target_q <= CENTER_Y10;
      p1_q     <= CENTER_Y10;
      p2_q     <= CENTER_Y10;
    end else begin
      state_q  <= state_d;
      lag_q    <= lag_d;
      target_q <= target_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lag_d    = lag_q;
    target_d = target_q;
    p1_d     = p1_q;
    p2_d     = p2_q;

    if (bus.refresh_tick) begin
      p1_d = manual_step(p1_q, up1_s, dn1_s, PADDLE_SPEED);

      case (state_q)
        AI_MANUAL: begin
          p2_d = manual_step(p2_q, up2_s, dn2_s, PADDLE_SPEED);
          if (bus.ai_enable) begin
            state_d = AI_TRACK;
            // Zero lag so the first TRACK tick samples the ball immediately.
            lag_d   = '0;
          end
        end
        AI_TRACK: begin
          if (!bus.ai_enable) begin
            // Leave paddle2 where the AI put it; buttons take over next tick.
            state_d = AI_MANUAL;
          end else begin
            if (lag_q == '0) begin
              target_d = ai_target(bus.ball_y);
            end
            lag_d = (lag_q == LAG_LAST) ? '0 : lag_q + LAG_W'(1);
            // Motion chases the previously sampled target, giving the AI its reaction delay.
            p2_d  = ai_step(p2_q, target_q, AI_SPEED, AI_DEADBAND);
          end
        end
        default: state_d = AI_MANUAL;
      endcase
    end
  end

  assign bus.paddle1_y = p1_q;
  assign bus.paddle2_y = p2_q;
  assign bus.ai_active = (state_q == AI_TRACK);

endmodule
